// File: rtl/seq_pkg.sv
// Shared types and encodings for the multicycle control sequencer: FSM states,
// opcode constants, instruction classes and datapath select encodings.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_R       = 3'd0,
    CL_IALU    = 3'd1,
    CL_LOAD    = 3'd2,
    CL_STORE   = 3'd3,
    CL_BRANCH  = 3'd4,
    CL_JAL     = 3'd5,
    CL_LUI     = 3'd6,
    CL_ILLEGAL = 3'd7
  } iclass_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] ALU_RR = 2'b00;
  localparam logic [1:0] ALU_RI = 2'b01;
  localparam logic [1:0] ALU_PI = 2'b10;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_XOR = 3'b100;
  localparam logic [2:0] ALUC_SLT = 3'b101;
  localparam logic [2:0] ALUC_SLL = 3'b110;
  localparam logic [2:0] ALUC_SRL = 3'b111;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // sltu folds onto slt and sra onto srl: the ALU has no unsigned/arith variants.
  function automatic logic [2:0] funct3_to_aluc(input logic [2:0] funct3, input logic use_sub);
    case (funct3)
      3'b000:  return use_sub ? ALUC_SUB : ALUC_ADD;
      3'b001:  return ALUC_SLL;
      3'b010,
      3'b011:  return ALUC_SLT;
      3'b100:  return ALUC_XOR;
      3'b101:  return ALUC_SRL;
      3'b110:  return ALUC_OR;
      default: return ALUC_AND;
    endcase
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction classifier: maps an instruction word to its class
// and the ALU operand select / operation used in EXEC.
module seq_decode
  import seq_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_t     iclass,
  output logic [2:0]  alu_control,
  output logic [1:0]  alu_sel
);

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    iclass      = CL_ILLEGAL;
    alu_control = ALUC_ADD;
    alu_sel     = ALU_RR;
    case (instr[6:0])
      OP_R: begin
        iclass      = CL_R;
        alu_control = funct3_to_aluc(instr[14:12], instr[30]);
      end
      OP_IALU: begin
        iclass      = CL_IALU;
        alu_sel     = ALU_RI;
        alu_control = funct3_to_aluc(instr[14:12], 1'b0);
      end
      OP_LOAD: begin
        iclass  = CL_LOAD;
        alu_sel = ALU_RI;
      end
      OP_STORE: begin
        iclass  = CL_STORE;
        alu_sel = ALU_RI;
      end
      OP_BRANCH: begin
        iclass      = CL_BRANCH;
        alu_control = ALUC_SUB;
      end
      OP_JAL: begin
        iclass  = CL_JAL;
        alu_sel = ALU_PI;
      end
      OP_LUI: begin
        iclass  = CL_LUI;
        alu_sel = ALU_RI;
      end
      default: iclass = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control FSM with a req/ack data-memory wait
// and timeout trap. Define SEQ_ILLEGAL_TRAP_EN to trap on illegal opcodes instead of NOP.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        bt,
  input  logic        mem_ack,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_sel,
  output logic [2:0]  alu_control,
  output logic        reg_write,
  output logic [1:0]  result_src,
  output logic        mem_req,
  output logic        mem_write,
  output logic        retire,
  output logic        halted,
  output logic        mem_err
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q, mem_err_d;

  iclass_t    iclass;
  logic [2:0] dec_alu_control;
  logic [1:0] dec_alu_sel;

  seq_decode u_decode (
    .instr       (instr),
    .iclass      (iclass),
    .alu_control (dec_alu_control),
    .alu_sel     (dec_alu_sel)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    mem_err_d   = mem_err_q;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = PC_PLUS4;
    alu_sel     = ALU_RR;
    alu_control = ALUC_ADD;
    reg_write   = 1'b0;
    result_src  = RES_ALU;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    retire      = 1'b0;
    halted      = 1'b0;
    mem_err     = mem_err_q;

    case (state_q)
      ST_FETCH: begin
        ir_we   = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (iclass == CL_ILLEGAL) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
          state_d = ST_TRAP;
`else
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = ST_FETCH;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_sel     = dec_alu_sel;
        alu_control = dec_alu_control;
        case (iclass)
          CL_BRANCH: begin
            pc_we   = 1'b1;
            pc_src  = bt ? PC_BRANCH : PC_PLUS4;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          default:           state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        mem_write = (iclass == CL_STORE);
        if (mem_ack) begin
          if (iclass == CL_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          // Counter holds the number of ack-less MEM cycles seen, including this one.
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_d == TIMEOUT) begin
            mem_err_d = 1'b1;
            state_d   = ST_TRAP;
          end
        end
      end
      ST_WB: begin
        reg_write = (instr[11:7] != 5'd0);
        if (iclass == CL_LOAD)     result_src = RES_MEM;
        else if (iclass == CL_JAL) result_src = RES_PC4;
        pc_we   = 1'b1;
        pc_src  = (iclass == CL_JAL) ? PC_JUMP : PC_PLUS4;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_TRAP: halted = 1'b1;
      default: state_d = ST_FETCH;
    endcase

    if (reset) begin
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_src      = PC_PLUS4;
      alu_sel     = ALU_RR;
      alu_control = ALUC_ADD;
      reg_write   = 1'b0;
      result_src  = RES_ALU;
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      retire      = 1'b0;
      halted      = 1'b0;
      mem_err     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

endmodule
